memory_block_reader_multi: RTL and testbench
============================================

MEMORY_BLOCK_READER_MULTI -- requirements
Module: memory_block_reader_multi

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning): ADDR_WIDTH, 32, address width; DATA_WIDTH, 32, beat width, one pixel per beat; BLOCK_W, 4, block width in pixels; BLOCK_H, 4, block height in lines; FRAME_Q_DEPTH, 4, pending-frame queue depth (power of 2, >=2).
REQ-002 The module SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-003 The module SHALL have these ports (name, direction, width, meaning): clk, in, 1, clock; rst, in, 1, async active-high reset.
REQ-004 frame_height, in, 16, lines per frame; frame_width, in, 16, pixels per line.
REQ-005 frame_ready, in, 1, one-cycle pulse: frame at base_addr_in is in memory; base_addr_in, in, ADDR_WIDTH, frame base byte address.
REQ-006 rvalid, in, 1; rlast, in, 1: read-data beat and last-beat flags from the burst master.
REQ-007 start_read, out, 1, one-cycle burst request; read_addr, out, ADDR_WIDTH; read_len, out, 32, beats; read_size, out, 3; read_burst, out, 2.
REQ-008 noise_estimation_en, out, 1, beat valid for the consumer; start_of_frame, out, 1, pulse; end_of_block, out, 1, pulse; frame_ready_for_wiener, out, 1, pulse; base_addr_out, out, ADDR_WIDTH, base of the frame being or last read.
REQ-009 q_overflow, out, 1, pulse on dropped frame_ready; cfg_err, out, 1, pulse on a skipped frame; len_err, out, 1, sticky burst-length mismatch flag.

Function
REQ-010 FSM states SHALL be IDLE, LOAD, ISSUE, WAIT_DATA, NEXT, DONE.
REQ-011 A frame_ready pulse SHALL push base_addr_in into the queue; when the queue is full, it SHALL drop the push and pulse q_overflow.
REQ-012 In IDLE with a non-empty queue, the FSM SHALL pop into LOAD, latch the base, frame_height and frame_width, and drive base_addr_out.
REQ-013 In LOAD, if frame_width is not a nonzero multiple of BLOCK_W or frame_height is not a nonzero multiple of BLOCK_H, the FSM SHALL pulse cfg_err and return to IDLE; otherwise it SHALL pulse start_of_frame and go to ISSUE.
REQ-014 ISSUE SHALL pulse start_read for exactly 1 cycle with read_len=BLOCK_W, read_size=log2(DATA_WIDTH/8), read_burst=2'b01 (INCR), then go to WAIT_DATA.
REQ-015 read_addr SHALL be base + ((by*BLOCK_H + ln)*frame_width + bx*BLOCK_W)*(DATA_WIDTH/8), computed at ADDR_WIDTH bits with wrap modulo 2^ADDR_WIDTH; bx, by and ln are the block column, block row and line-in-block counters.
REQ-016 Iteration order SHALL be: line ln fastest, then bx, then by (block raster order).
REQ-017 In WAIT_DATA, noise_estimation_en SHALL equal rvalid; a beat counter SHALL count rvalid beats; rvalid&&rlast SHALL move the FSM to NEXT.
REQ-018 If rlast arrives with a beat count other than BLOCK_W, len_err SHALL set and stay set until reset.
REQ-019 NEXT SHALL advance the counters and pulse end_of_block when ln wraps; it SHALL go to ISSUE, or to DONE after the last line of the last block.
REQ-020 DONE SHALL pulse frame_ready_for_wiener for 1 cycle and return to IDLE; back-to-back queued frames SHALL start with no further idle cycle.
REQ-021 A push and a pop in the same cycle SHALL both take effect and leave the occupancy unchanged; a push into an empty queue SHALL be popped no earlier than the next cycle.
REQ-022 rvalid outside WAIT_DATA SHALL be ignored and SHALL NOT assert noise_estimation_en.

Reset
REQ-023 rst SHALL immediately clear, including mid-burst: FSM to IDLE, queue empty, counters 0, all outputs 0, len_err 0.
REQ-024 After rst deasserts, no start_read SHALL occur until a new frame_ready.

Configuration
REQ-025 With FRAME_QUEUE_EN defined, the queue SHALL be FRAME_Q_DEPTH entries deep.
REQ-026 Without FRAME_QUEUE_EN, a single holding register SHALL replace the queue; frame_ready while it is occupied or while busy (not IDLE) SHALL be dropped and pulse q_overflow.

Verification
REQ-027 8x8 frame, base 0x0, BLOCK 4x4, single frame_ready -> start_of_frame, 16 bursts of read_len=4; addresses 0x00,0x20,0x40,0x60,0x10,0x30,0x50,0x70,0x80,...; 4 end_of_block pulses; 1 frame_ready_for_wiener; 64 noise_estimation_en beats.
REQ-028 Three frame_ready pulses (0x0, 0x100, 0x200) 10 cycles apart, FRAME_QUEUE_EN set -> three frames in order, base_addr_out 0x0, 0x100, 0x200, q_overflow never asserted.
REQ-029 FRAME_Q_DEPTH=4 with 6 pulses while busy -> exactly 1 q_overflow pulse; 5 frames complete. Without FRAME_QUEUE_EN -> the 2nd pulse onward drops.
REQ-030 frame_width=6 -> cfg_err pulse, no start_read, FSM back to IDLE.
REQ-031 Slave returns rlast on beat 3 -> len_err=1 and held; assert rst during the 5th burst -> all outputs 0 next edge, no further start_read.

Source files
------------

// File: rtl/memory_block_reader_multi.sv
// Block-raster frame reader: walks queued frames in BLOCK_W x BLOCK_H tiles, one INCR burst per tile line.
// Define FRAME_QUEUE_EN for a FRAME_Q_DEPTH-entry frame queue; otherwise a single holding register is used.
module memory_block_reader_multi #(
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned BLOCK_W       = 4,
  parameter int unsigned BLOCK_H       = 4,
  parameter int unsigned FRAME_Q_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           frame_height,
  input  logic [15:0]           frame_width,
  input  logic                  frame_ready,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  input  logic                  rvalid,
  input  logic                  rlast,
  output logic                  start_read,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic [31:0]           read_len,
  output logic [2:0]            read_size,
  output logic [1:0]            read_burst,
  output logic                  noise_estimation_en,
  output logic                  start_of_frame,
  output logic                  end_of_block,
  output logic                  frame_ready_for_wiener,
  output logic [ADDR_WIDTH-1:0] base_addr_out,
  output logic                  q_overflow,
  output logic                  cfg_err,
  output logic                  len_err
);

  localparam int unsigned BYTES     = DATA_WIDTH / 8;
  localparam int unsigned SIZE_LOG2 = $clog2(BYTES);
  localparam int unsigned CNT_W     = 16;

  if (FRAME_Q_DEPTH < 2 || (FRAME_Q_DEPTH & (FRAME_Q_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FRAME_Q_DEPTH must be a power of 2 and at least 2");
  end

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_DATA, NEXT, DONE} state_t;

  state_t                  state;
  logic                    q_empty;
  logic                    pop;
  logic                    push_ok;
  logic [ADDR_WIDTH-1:0]   q_head;

  // Pop only from registered occupancy, so a fresh push is seen one cycle later
  assign pop = (state == IDLE) && !q_empty;

`ifdef FRAME_QUEUE_EN
  localparam int unsigned PTR_W = $clog2(FRAME_Q_DEPTH);
  localparam int unsigned QCW   = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] q_mem [FRAME_Q_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [QCW-1:0]        q_count;

  assign q_empty = (q_count == '0);
  assign push_ok = frame_ready && ((q_count != QCW'(FRAME_Q_DEPTH)) || pop);
  assign q_head  = q_mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   q_count <= q_count + QCW'(1);
        2'b01:   q_count <= q_count - QCW'(1);
        default: q_count <= q_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) q_mem[wr_ptr] <= base_addr_in;
  end
`else
  logic                  hold_valid;
  logic [ADDR_WIDTH-1:0] hold_addr;

  assign q_empty = !hold_valid;
  assign push_ok = frame_ready && !hold_valid && (state == IDLE);
  assign q_head  = hold_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_addr  <= '0;
    end else if (push_ok) begin
      hold_valid <= 1'b1;
      hold_addr  <= base_addr_in;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  logic [ADDR_WIDTH-1:0] base_q;
  logic [15:0]           frame_w_q;
  logic [15:0]           frame_h_q;
  logic [CNT_W-1:0]      bx;
  logic [CNT_W-1:0]      by;
  logic [CNT_W-1:0]      ln;
  logic [CNT_W-1:0]      beat_cnt;
  logic [ADDR_WIDTH-1:0] line_idx;
  logic [ADDR_WIDTH-1:0] pix_off;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic                  cfg_ok;
  logic                  last_ln;
  logic                  last_bx;
  logic                  last_by;

  // Burst address for the current tile line, wrapping at ADDR_WIDTH bits
  always_comb begin
    line_idx   = ADDR_WIDTH'(by) * ADDR_WIDTH'(BLOCK_H) + ADDR_WIDTH'(ln);
    pix_off    = line_idx * ADDR_WIDTH'(frame_w_q) + ADDR_WIDTH'(bx) * ADDR_WIDTH'(BLOCK_W);
    issue_addr = base_q + pix_off * ADDR_WIDTH'(BYTES);
  end

  assign cfg_ok  = (frame_w_q != 16'd0) && (frame_h_q != 16'd0) &&
                   ((frame_w_q % 16'(BLOCK_W)) == 16'd0) &&
                   ((frame_h_q % 16'(BLOCK_H)) == 16'd0);
  assign last_ln = (ln == CNT_W'(BLOCK_H - 1));
  assign last_bx = ((32'(bx) + 32'd1) * 32'(BLOCK_W)) == 32'(frame_w_q);
  assign last_by = ((32'(by) + 32'd1) * 32'(BLOCK_H)) == 32'(frame_h_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= IDLE;
      base_q                 <= '0;
      frame_w_q              <= '0;
      frame_h_q              <= '0;
      bx                     <= '0;
      by                     <= '0;
      ln                     <= '0;
      beat_cnt               <= '0;
      start_read             <= 1'b0;
      read_addr              <= '0;
      read_len               <= '0;
      read_size              <= '0;
      read_burst             <= '0;
      noise_estimation_en    <= 1'b0;
      start_of_frame         <= 1'b0;
      end_of_block           <= 1'b0;
      frame_ready_for_wiener <= 1'b0;
      base_addr_out          <= '0;
      q_overflow             <= 1'b0;
      cfg_err                <= 1'b0;
      len_err                <= 1'b0;
    end else begin
      start_read             <= 1'b0;
      noise_estimation_en    <= 1'b0;
      start_of_frame         <= 1'b0;
      end_of_block           <= 1'b0;
      frame_ready_for_wiener <= 1'b0;
      cfg_err                <= 1'b0;
      q_overflow             <= frame_ready && !push_ok;
      case (state)
        IDLE: begin
          if (pop) begin
            base_q        <= q_head;
            base_addr_out <= q_head;
            frame_w_q     <= frame_width;
            frame_h_q     <= frame_height;
            state         <= LOAD;
          end
        end
        LOAD: begin
          bx <= '0;
          by <= '0;
          ln <= '0;
          if (cfg_ok) begin
            start_of_frame <= 1'b1;
            state          <= ISSUE;
          end else begin
            cfg_err <= 1'b1;
            state   <= IDLE;
          end
        end
        ISSUE: begin
          start_read <= 1'b1;
          read_addr  <= issue_addr;
          read_len   <= 32'(BLOCK_W);
          read_size  <= 3'(SIZE_LOG2);
          read_burst <= 2'b01;
          beat_cnt   <= '0;
          state      <= WAIT_DATA;
        end
        WAIT_DATA: begin
          noise_estimation_en <= rvalid;
          if (rvalid) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (rlast) begin
              if (beat_cnt + CNT_W'(1) != CNT_W'(BLOCK_W)) len_err <= 1'b1;
              state <= NEXT;
            end
          end
        end
        // Line fastest, then block column, then block row
        NEXT: begin
          state <= ISSUE;
          if (last_ln) begin
            ln           <= '0;
            end_of_block <= 1'b1;
            if (last_bx) begin
              bx <= '0;
              if (last_by) state <= DONE;
              else         by    <= by + CNT_W'(1);
            end else begin
              bx <= bx + CNT_W'(1);
            end
          end else begin
            ln <= ln + CNT_W'(1);
          end
        end
        DONE: begin
          frame_ready_for_wiener <= 1'b1;
          state                  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_block_reader_multi.sv
// Scoreboard bench for memory_block_reader_multi with a behavioural burst slave.
`timescale 1ns/1ps
module tb_memory_block_reader_multi;

  localparam int unsigned AW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned BH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   frame_height, frame_width;
  logic          frame_ready;
  logic [AW-1:0] base_addr_in;
  logic          rvalid, rlast;
  logic          start_read;
  logic [AW-1:0] read_addr;
  logic [31:0]   read_len;
  logic [2:0]    read_size;
  logic [1:0]    read_burst;
  logic          noise_estimation_en, start_of_frame, end_of_block, frame_ready_for_wiener;
  logic [AW-1:0] base_addr_out;
  logic          q_overflow, cfg_err, len_err;

  always #5 clk = ~clk;

  memory_block_reader_multi #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(32), .BLOCK_W(BW), .BLOCK_H(BH), .FRAME_Q_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .frame_height(frame_height), .frame_width(frame_width),
    .frame_ready(frame_ready), .base_addr_in(base_addr_in),
    .rvalid(rvalid), .rlast(rlast),
    .start_read(start_read), .read_addr(read_addr), .read_len(read_len),
    .read_size(read_size), .read_burst(read_burst),
    .noise_estimation_en(noise_estimation_en), .start_of_frame(start_of_frame),
    .end_of_block(end_of_block), .frame_ready_for_wiener(frame_ready_for_wiener),
    .base_addr_out(base_addr_out), .q_overflow(q_overflow),
    .cfg_err(cfg_err), .len_err(len_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [AW-1:0] exp_addr[$];
  logic [AW-1:0] exp_base[$];
  int n_burst, n_sof, n_eob, n_wiener, n_beat, n_ovf, n_cfg;
  bit short_next = 1'b0;

  // Reference walk: line fastest, then block column, then block row
  task automatic expect_frame(input logic [AW-1:0] base, input int w, input int h);
    logic [AW-1:0] a;
    exp_base.push_back(base);
    for (int by = 0; by < h / BH; by++)
      for (int bx = 0; bx < w / BW; bx++)
        for (int ln = 0; ln < BH; ln++) begin
          a = base + AW'(((by * BH + ln) * w + bx * BW) * 4);
          exp_addr.push_back(a);
        end
  endtask

  task automatic clear_counts();
    n_burst = 0; n_sof = 0; n_eob = 0; n_wiener = 0; n_beat = 0; n_ovf = 0; n_cfg = 0;
  endtask

  task automatic pulse_frame(input logic [AW-1:0] base, input bit accept);
    @(posedge clk); #1;
    frame_ready  = 1'b1;
    base_addr_in = base;
    if (accept) expect_frame(base, int'(frame_width), int'(frame_height));
    @(posedge clk); #1;
    frame_ready = 1'b0;
  endtask

  task automatic wait_frames(input string tag, input int n, input int budget);
    int c = 0;
    while (n_wiener < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    check(tag, 64'(n_wiener), 64'(n));
    repeat (10) @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start_read"}, 64'(start_read), 64'(0));
    check({tag, "_read_addr"}, 64'(read_addr), 64'(0));
    check({tag, "_noise_en"}, 64'(noise_estimation_en), 64'(0));
    check({tag, "_sof"}, 64'(start_of_frame), 64'(0));
    check({tag, "_eob"}, 64'(end_of_block), 64'(0));
    check({tag, "_wiener"}, 64'(frame_ready_for_wiener), 64'(0));
    check({tag, "_base_out"}, 64'(base_addr_out), 64'(0));
    check({tag, "_q_overflow"}, 64'(q_overflow), 64'(0));
    check({tag, "_cfg_err"}, 64'(cfg_err), 64'(0));
    check({tag, "_len_err"}, 64'(len_err), 64'(0));
  endtask

  // Output monitor: bursts and frame starts are checked against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (start_read) begin
        n_burst++;
        if (exp_addr.size() == 0) check("unexpected_start_read", 64'(1), 64'(0));
        else check("read_addr", 64'(read_addr), 64'(exp_addr.pop_front()));
        check("read_len", 64'(read_len), 64'(BW));
        check("read_size", 64'(read_size), 64'(2));
        check("read_burst", 64'(read_burst), 64'(1));
      end
      if (start_of_frame) begin
        n_sof++;
        if (exp_base.size() == 0) check("unexpected_sof", 64'(1), 64'(0));
        else check("base_addr_out", 64'(base_addr_out), 64'(exp_base.pop_front()));
      end
      if (end_of_block)           n_eob++;
      if (frame_ready_for_wiener) n_wiener++;
      if (noise_estimation_en)    n_beat++;
      if (q_overflow)             n_ovf++;
      if (cfg_err)                n_cfg++;
    end
  end

  // Burst slave: one-cycle latency, occasional gaps, optional early rlast
  initial begin
    rvalid = 1'b0;
    rlast  = 1'b0;
    forever begin
      @(negedge clk);
      if (start_read && !rst) begin
        int nb;
        nb = short_next ? 3 : int'(BW);
        short_next = 1'b0;
        @(negedge clk);
        for (int b = 0; b < nb && !rst; b++) begin
          if ($urandom_range(0, 3) == 0) begin
            rvalid = 1'b0;
            rlast  = 1'b0;
            @(negedge clk);
          end
          rvalid = 1'b1;
          rlast  = (b == nb - 1);
          @(negedge clk);
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_frames, exp_ovf, c;
    rst = 1'b1;
    frame_ready = 1'b0;
    base_addr_in = '0;
    frame_width = 16'd8;
    frame_height = 16'd8;
    clear_counts();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    check("no_read_after_reset", 64'(n_burst), 64'(0));

    // Single 8x8 frame
    clear_counts();
    pulse_frame(32'h0, 1'b1);
    wait_frames("frame8x8_done", 1, 2000);
    check("frame8x8_bursts", 64'(n_burst), 64'(16));
    check("frame8x8_eob", 64'(n_eob), 64'(4));
    check("frame8x8_sof", 64'(n_sof), 64'(1));
    check("frame8x8_beats", 64'(n_beat), 64'(64));
    check("frame8x8_ovf", 64'(n_ovf), 64'(0));
    check("frame8x8_len_err", 64'(len_err), 64'(0));
    check("frame8x8_sb_empty", 64'(exp_addr.size()), 64'(0));

    // Three frames 10 cycles apart, 16x4
    clear_counts();
    frame_width = 16'd16;
    frame_height = 16'd4;
`ifdef FRAME_QUEUE_EN
    exp_frames = 3; exp_ovf = 0;
`else
    exp_frames = 1; exp_ovf = 2;
`endif
    for (int i = 0; i < 3; i++) begin
      pulse_frame(AW'(i * 32'h100), (i == 0) || (exp_frames == 3));
      repeat (9) @(posedge clk);
    end
    wait_frames("three_done", exp_frames, 4000);
    check("three_ovf", 64'(n_ovf), 64'(exp_ovf));
    check("three_sof", 64'(n_sof), 64'(exp_frames));
    check("three_bursts", 64'(n_burst), 64'(exp_frames * 16));
    check("three_base_empty", 64'(exp_base.size()), 64'(0));

    // Six pulses while busy, 4x4 frames
    clear_counts();
    frame_width = 16'd4;
    frame_height = 16'd4;
`ifdef FRAME_QUEUE_EN
    exp_frames = 5; exp_ovf = 1;
`else
    exp_frames = 1; exp_ovf = 5;
`endif
    pulse_frame(32'h1000, 1'b1);
    for (int i = 1; i < 6; i++) begin
      @(posedge clk);
      pulse_frame(AW'(32'h1000 + i * 32'h100), (exp_frames == 5) && (i < 5));
    end
    wait_frames("burst6_done", exp_frames, 4000);
    check("burst6_ovf", 64'(n_ovf), 64'(exp_ovf));
    check("burst6_sof", 64'(n_sof), 64'(exp_frames));
    check("burst6_beats", 64'(n_beat), 64'(exp_frames * 16));

    // Bad geometry, then a wrapping frame to show recovery
    clear_counts();
    frame_width = 16'd6;
    frame_height = 16'd8;
    pulse_frame(32'h3000, 1'b0);
    repeat (20) @(posedge clk);
    check("cfg_w6_err", 64'(n_cfg), 64'(1));
    frame_width = 16'd8;
    frame_height = 16'd0;
    pulse_frame(32'h3100, 1'b0);
    repeat (20) @(posedge clk);
    check("cfg_h0_err", 64'(n_cfg), 64'(2));
    check("cfg_no_read", 64'(n_burst), 64'(0));
    check("cfg_no_sof", 64'(n_sof), 64'(0));
    frame_width = 16'd4;
    frame_height = 16'd8;
    pulse_frame(32'hFFFF_FFC0, 1'b1);
    wait_frames("wrap_done", 1, 2000);
    check("wrap_bursts", 64'(n_burst), 64'(8));
    check("wrap_eob", 64'(n_eob), 64'(2));

    // Short burst sets sticky len_err
    clear_counts();
    frame_width = 16'd4;
    frame_height = 16'd4;
    short_next = 1'b1;
    pulse_frame(32'h4000, 1'b1);
    wait_frames("short_done", 1, 2000);
    check("short_len_err", 64'(len_err), 64'(1));
    check("short_beats", 64'(n_beat), 64'(15));
    repeat (20) @(posedge clk);
    check("len_err_held", 64'(len_err), 64'(1));

    // Reset during the fifth burst
    clear_counts();
    frame_width = 16'd8;
    frame_height = 16'd8;
    pulse_frame(32'h5000, 1'b1);
    c = 0;
    while (n_burst < 5 && c < 1000) begin
      @(posedge clk);
      c++;
    end
    check("burst5_reached", 64'(n_burst), 64'(5));
    @(posedge clk); #1;
    rst = 1'b1;
    exp_addr.delete();
    exp_base.delete();
    @(negedge clk);
    check_all_zero("midrst");
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    repeat (60) @(posedge clk);
    check("midrst_no_read", 64'(n_burst), 64'(5));
    check("midrst_len_err", 64'(len_err), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
